// File: rtl/mtm_custom_pattern_checker.sv
// mtm_custom_pattern_checker
// Avalon-ST sink that compares each received word against a software-loaded
// pattern held in an internal RAM and counts mismatches over a programmed
// payload length. CSR slave exposes lengths, control/status and error count.
// Optional build macro: CHECKER_STOP_ON_ERROR_EN (first mismatch ends the run).
module mtm_custom_pattern_checker #(
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_PATTERN_LENGTH = 64,
  parameter int ADDRESS_WIDTH      = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                csr_address,
  input  logic [31:0]               csr_writedata,
  input  logic                      csr_write,
  input  logic                      csr_read,
  input  logic [3:0]                csr_byteenable,
  output logic [31:0]               csr_readdata,
  input  logic [ADDRESS_WIDTH-1:0]  pattern_address,
  input  logic [DATA_WIDTH-1:0]     pattern_writedata,
  input  logic                      pattern_write,
  input  logic [DATA_WIDTH/8-1:0]   pattern_byteenable,
  input  logic [DATA_WIDTH-1:0]     snk_data,
  input  logic                      snk_valid,
  output logic                      snk_ready
);

  localparam int          NUM_LANES = DATA_WIDTH / 8;
  localparam logic [15:0] MAX_LEN16 = 16'(MAX_PATTERN_LENGTH);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

  state_t                   r_state, w_state_next;
  logic [31:0]              r_payload_len;
  logic [31:0]              r_pattern_cfg;
  logic [31:0]              r_err_cnt;
  logic [31:0]              r_beat_cnt;
  logic                     r_done, r_error;
  logic [ADDRESS_WIDTH-1:0] r_ptr;
  logic [ADDRESS_WIDTH:0]   r_len;
  logic [DATA_WIDTH-1:0]    r_ram [MAX_PATTERN_LENGTH];
  logic [DATA_WIDTH-1:0]    r_expected;
  logic [31:0]              r_readdata;

  logic                     w_idle, w_ready, w_ctrl_wr, w_start, w_clear;
  logic                     w_accept, w_mismatch, w_last, w_run_end;
  logic [ADDRESS_WIDTH:0]   w_len_clamped;
  logic [ADDRESS_WIDTH-1:0] w_ptr_init, w_ptr_next, w_rd_addr;
  logic [15:0]              w_pos;

  assign w_idle    = (r_state == S_IDLE);
  assign w_ready   = (r_state == S_RUN);
  assign snk_ready = w_ready;

  // Control writes only take effect when the top byte lane is enabled
  assign w_ctrl_wr = csr_write && (csr_address == 2'd2) && csr_byteenable[3];
  assign w_start   = w_ctrl_wr && csr_writedata[24] && w_idle &&
                     (r_payload_len != 32'd0) && (r_pattern_cfg[15:0] != 16'd0);
  // Clear is honoured only in IDLE; a start in the same write clears anyway
  assign w_clear   = w_ctrl_wr && csr_writedata[31] && w_idle;

  // Oversized pattern lengths are clamped to the RAM depth
  assign w_len_clamped = (r_pattern_cfg[15:0] > MAX_LEN16) ?
                         MAX_LEN16[ADDRESS_WIDTH:0] : r_pattern_cfg[ADDRESS_WIDTH:0];
  assign w_pos         = r_pattern_cfg[31:16];
  assign w_ptr_init    = (w_pos >= {{(15 - ADDRESS_WIDTH){1'b0}}, w_len_clamped}) ?
                         '0 : w_pos[ADDRESS_WIDTH-1:0];

  assign w_accept   = snk_valid && w_ready;
  assign w_mismatch = w_accept && (snk_data != r_expected);
  assign w_last     = w_accept && (r_beat_cnt == (r_payload_len - 32'd1));
  assign w_ptr_next = ({1'b0, r_ptr} == (r_len - 1'b1)) ? '0 : (r_ptr + 1'b1);
  // PRIME fetches the first word; afterwards fetch ahead so beats can be back-to-back
  assign w_rd_addr  = (r_state == S_PRIME) ? r_ptr : w_ptr_next;

`ifdef CHECKER_STOP_ON_ERROR_EN
  assign w_run_end = w_last || w_mismatch;
`else
  assign w_run_end = w_last;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_next = S_PRIME;
      S_PRIME: w_state_next = S_RUN;
      S_RUN:   if (w_run_end) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Byte-lane CSR writes for payload length and pattern position/length
  always_ff @(posedge clk) begin
    if (reset) begin
      r_payload_len <= '0;
      r_pattern_cfg <= '0;
    end else if (csr_write) begin
      for (int i = 0; i < 4; i++) begin
        if (csr_byteenable[i]) begin
          if (csr_address == 2'd0) r_payload_len[i*8 +: 8] <= csr_writedata[i*8 +: 8];
          if (csr_address == 2'd1) r_pattern_cfg[i*8 +: 8] <= csr_writedata[i*8 +: 8];
        end
      end
    end
  end

  // Pattern RAM write port with per-byte enables, independent of checker state
  always_ff @(posedge clk) begin
    if (pattern_write) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (pattern_byteenable[i])
          r_ram[pattern_address][i*8 +: 8] <= pattern_writedata[i*8 +: 8];
      end
    end
  end

  // Registered RAM read into the expected-word register
  always_ff @(posedge clk) begin
    if ((r_state == S_PRIME) || w_accept) r_expected <= r_ram[w_rd_addr];
  end

  // Pattern pointer and beat counter, initialised on start, stepped per accept
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr      <= '0;
      r_len      <= '0;
      r_beat_cnt <= '0;
    end else if (w_start) begin
      r_ptr      <= w_ptr_init;
      r_len      <= w_len_clamped;
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      r_ptr      <= w_ptr_next;
      r_beat_cnt <= r_beat_cnt + 32'd1;
    end
  end

  // Sticky status and saturating error counter
  always_ff @(posedge clk) begin
    if (reset || w_start || w_clear) begin
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_mismatch) begin
        r_error <= 1'b1;
        if (r_err_cnt != 32'hFFFF_FFFF) r_err_cnt <= r_err_cnt + 32'd1;
      end
      if (w_run_end) r_done <= 1'b1;
    end
  end

  // CSR read data, registered on read strobe and held otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= '0;
    end else if (csr_read) begin
      case (csr_address)
        2'd0:    r_readdata <= r_payload_len;
        2'd1:    r_readdata <= r_pattern_cfg;
        2'd2:    r_readdata <= {29'd0, r_error, r_done, !w_idle};
        default: r_readdata <= r_err_cnt;
      endcase
    end
  end

  assign csr_readdata = r_readdata;

endmodule

// File: tb/tb_mtm_custom_pattern_checker.sv
// Testbench for mtm_custom_pattern_checker: directed stimulus pushes expected
// responses into queues; a negedge monitor pops and compares them.
module tb_mtm_custom_pattern_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  csr_address;
  logic [31:0] csr_writedata;
  logic        csr_write;
  logic        csr_read;
  logic [3:0]  csr_byteenable;
  logic [31:0] csr_readdata;
  logic [5:0]  pattern_address;
  logic [31:0] pattern_writedata;
  logic        pattern_write;
  logic [3:0]  pattern_byteenable;
  logic [31:0] snk_data;
  logic        snk_valid;
  logic        snk_ready;

  mtm_custom_pattern_checker #(
    .DATA_WIDTH(32), .MAX_PATTERN_LENGTH(64), .ADDRESS_WIDTH(6)
  ) dut (
    .clk(clk), .reset(reset),
    .csr_address(csr_address), .csr_writedata(csr_writedata),
    .csr_write(csr_write), .csr_read(csr_read),
    .csr_byteenable(csr_byteenable), .csr_readdata(csr_readdata),
    .pattern_address(pattern_address), .pattern_writedata(pattern_writedata),
    .pattern_write(pattern_write), .pattern_byteenable(pattern_byteenable),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready)
  );

  always #5 clk = ~clk;

  // kind: 0 = CSR read result, 1 = snk_ready, 2 = accepted beats since last check, 3 = csr_readdata now
  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t       rd_q[$];
  item_t       probe_q[$];
  logic [31:0] tx_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          beat_cnt = 0;
  logic        rd_pend  = 1'b0;

  always @(posedge clk) rd_pend <= csr_read;

  // Monitor: compares every pending expectation against what the DUT presents
  always @(negedge clk) begin
    item_t       it;
    logic [31:0] act;
    if (rd_pend) begin
      n_checks++;
      if (rd_q.size() == 0) begin
        n_errors++;
        $display("FAIL csr_read_unexpected: got 0x%08h with no expected value queued", csr_readdata);
      end else begin
        it = rd_q.pop_front();
        if (csr_readdata !== it.exp) begin
          n_errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", it.name, csr_readdata, it.exp);
        end
      end
    end
    while (probe_q.size() > 0) begin
      it = probe_q.pop_front();
      case (it.kind)
        1:       act = {31'd0, snk_ready};
        2:       act = 32'(beat_cnt);
        default: act = csr_readdata;
      endcase
      n_checks++;
      if (act !== it.exp) begin
        n_errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", it.name, act, it.exp);
      end
      if (it.kind == 2) beat_cnt = 0;
    end
    if (snk_valid && snk_ready && !reset) beat_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int k, input logic [31:0] e, input string nm);
    item_t it;
    it.kind = k; it.exp = e; it.name = nm;
    probe_q.push_back(it);
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    csr_address = a; csr_writedata = d; csr_byteenable = be; csr_write = 1'b1;
    tick();
    csr_write = 1'b0; csr_byteenable = 4'h0;
  endtask

  task automatic csr_rd(input logic [1:0] a, input logic [31:0] e, input string nm);
    item_t it;
    it.kind = 0; it.exp = e; it.name = nm;
    rd_q.push_back(it);
    csr_address = a; csr_read = 1'b1;
    tick();
    csr_read = 1'b0;
  endtask

  task automatic pat_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    pattern_address = a; pattern_writedata = d; pattern_byteenable = be; pattern_write = 1'b1;
    tick();
    pattern_write = 1'b0;
  endtask

  task automatic load_seq(input int first, input int len, input int n);
    tx_q.delete();
    for (int k = 0; k < n; k++) tx_q.push_back(32'((first + k) % len));
  endtask

  task automatic start_run(input logic [31:0] payload, input logic [31:0] cfg);
    csr_wr(2'd0, payload, 4'hF);
    csr_wr(2'd1, cfg, 4'hF);
    csr_wr(2'd2, 32'h0100_0000, 4'h8);
  endtask

  // Drive up to n beats from tx_q; invalid cycles carry garbage data
  task automatic send_beats(input int n, input bit toggle, input int budget);
    int acc = 0;
    bit hit;
    for (int c = 0; c < budget && acc < n; c++) begin
      snk_valid = toggle ? (c % 2 == 0) : 1'b1;
      snk_data  = snk_valid ? tx_q[acc] : (32'hBAD0_0000 + 32'(c));
      @(negedge clk);
      hit = snk_valid && snk_ready;
      tick();
      if (hit) acc++;
    end
    snk_valid = 1'b0;
    snk_data  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; csr_address = '0; csr_writedata = '0; csr_write = 1'b0; csr_read = 1'b0;
    csr_byteenable = '0; pattern_address = '0; pattern_writedata = '0; pattern_write = 1'b0;
    pattern_byteenable = '0; snk_data = '0; snk_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    probe(1, 32'd0, "rst_snk_ready");
    probe(3, 32'd0, "rst_readdata");
    csr_rd(2'd0, 32'd0, "rst_payload");
    csr_rd(2'd1, 32'd0, "rst_cfg");
    csr_rd(2'd2, 32'd0, "rst_status");
    csr_rd(2'd3, 32'd0, "rst_errcnt");

    // CSR byte enables
    csr_wr(2'd1, 32'h1234_5678, 4'b0101);
    csr_rd(2'd1, 32'h0034_0078, "cfg_byteenable");

    // Pattern RAM: RAM[i] = i, entry 1 built with a partial-lane write
    for (int i = 0; i < 8; i++) pat_wr(6'(i), 32'(i), 4'hF);
    pat_wr(6'd1, 32'hFFFF_0001, 4'hF);
    pat_wr(6'd1, 32'h0000_0000, 4'b1100);

    // Basic pass
    load_seq(0, 8, 32);
    start_run(32'd32, 32'h0000_0008);
    probe(1, 32'd0, "prime_ready_low");
    csr_rd(2'd2, 32'h1, "basic_busy");
    probe(1, 32'd1, "run_ready_high");
    send_beats(32, 1'b0, 200);
    probe(1, 32'd0, "basic_ready_end");
    probe(2, 32'd32, "basic_beats");
    csr_rd(2'd2, 32'h2, "basic_status");
    csr_rd(2'd3, 32'd0, "basic_errcnt");

`ifndef CHECKER_STOP_ON_ERROR_EN
    // Single corruption, full payload consumed
    load_seq(0, 8, 32);
    tx_q[10] = 32'hDEAD_BEEF;
    start_run(32'd32, 32'h0000_0008);
    send_beats(32, 1'b0, 200);
    probe(2, 32'd32, "corrupt_beats");
    probe(1, 32'd0, "corrupt_ready_end");
    csr_rd(2'd2, 32'h6, "corrupt_status");
    csr_rd(2'd3, 32'd1, "corrupt_errcnt");
`else
    // Stop on first mismatch at beat 3
    load_seq(0, 8, 32);
    tx_q[3] = 32'hDEAD_BEEF;
    start_run(32'd32, 32'h0000_0008);
    send_beats(32, 1'b0, 60);
    probe(2, 32'd4, "stop_beats");
    probe(1, 32'd0, "stop_ready_low");
    csr_rd(2'd2, 32'h6, "stop_status");
    csr_rd(2'd3, 32'd1, "stop_errcnt");
`endif

    // Clear status in IDLE
    csr_wr(2'd2, 32'h8000_0000, 4'h8);
    csr_rd(2'd2, 32'h0, "clear_status");
    csr_rd(2'd3, 32'd0, "clear_errcnt");

    // Stalls: valid toggles every cycle
    load_seq(0, 8, 32);
    start_run(32'd32, 32'h0000_0008);
    send_beats(32, 1'b1, 300);
    probe(2, 32'd32, "stall_beats");
    probe(1, 32'd0, "stall_ready_end");
    csr_rd(2'd2, 32'h2, "stall_status");
    csr_rd(2'd3, 32'd0, "stall_errcnt");

    // Offset wrap: position 5, length 8, payload 10
    load_seq(5, 8, 10);
    start_run(32'd10, 32'h0005_0008);
    send_beats(10, 1'b0, 100);
    probe(2, 32'd10, "offset_beats");
    csr_rd(2'd2, 32'h2, "offset_status");
    csr_rd(2'd3, 32'd0, "offset_errcnt");

    // Position beyond length falls back to pointer 0
    load_seq(0, 8, 3);
    start_run(32'd3, 32'h0009_0008);
    send_beats(3, 1'b0, 100);
    probe(2, 32'd3, "pos_ge_len_beats");
    csr_rd(2'd3, 32'd0, "pos_ge_len_errcnt");

    // Reset mid-run after 12 beats
    load_seq(0, 8, 32);
    start_run(32'd32, 32'h0000_0008);
    send_beats(12, 1'b0, 100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    probe(1, 32'd0, "midrst_ready");
    probe(2, 32'd12, "midrst_beats");
    csr_rd(2'd2, 32'h0, "midrst_status");
    csr_rd(2'd3, 32'd0, "midrst_errcnt");
    csr_rd(2'd0, 32'd0, "midrst_payload");

    // New run after reset completes normally
    load_seq(0, 8, 32);
    start_run(32'd32, 32'h0000_0008);
    send_beats(32, 1'b0, 200);
    probe(2, 32'd32, "rerun_beats");
    csr_rd(2'd2, 32'h2, "rerun_status");

    // Start with zero payload is ignored: stays idle, done retained
    csr_wr(2'd0, 32'd0, 4'hF);
    csr_wr(2'd2, 32'h0100_0000, 4'h8);
    probe(1, 32'd0, "zero_payload_ready");
    csr_rd(2'd2, 32'h2, "zero_payload_status");

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
